// File: rtl/cordic_pkg.sv
// Shared types and constants for the hyperbolic CORDIC scheduler.
// Optional sqrt operand preparation is controlled by CORDIC_SQRT_PREP_EN.
package cordic_pkg;

  // Default operand/result width (signed Q1.15)
  localparam int DEF_W      = 16;

  // 1.205 * 2^15: hyperbolic gain compensation applied to sqrt operands
  localparam int KH         = 39485;

  // 0.25 in Q1.15: offset used to form (a + 1/4) and (a - 1/4)
  localparam int QUARTER    = 'h2000;

  // Arithmetic right shift applied to the offset sums before scaling
  localparam int PREP_SHIFT = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/cordic_sqrt_prep.sv
// Combinational sqrt operand builder: from a, produce
//   x = ((a + 1/4) >>> 2) * KH   and   y = ((a - 1/4) >>> 2) * KH
// keeping product bits [2W-2:W-1] (truncated). Only instantiated when
// CORDIC_SQRT_PREP_EN is defined.
module cordic_sqrt_prep
  import cordic_pkg::*;
#(
  parameter int W = DEF_W
)(
  input  logic [W-1:0] a,
  output logic [W-1:0] x,
  output logic [W-1:0] y
);

  // Two guard bits keep a +/- 1/4 from overflowing
  localparam int EW = W + 2;
  localparam int PW = EW + 18;

  localparam logic signed [EW-1:0] Q_EXT = EW'(QUARTER);
  localparam logic signed [PW-1:0] K_EXT = PW'(KH);

  logic signed [EW-1:0] a_ext, s_val, d_val, s_sh, d_sh;
  logic signed [PW-1:0] s_prod, d_prod;
  logic                 unused_bits;

  // Offset, shift and scale both terms; the low PW bits of the product are
  // exact in two's complement, so the selected slice is the truncated result
  always_comb begin
    a_ext  = $signed({{2{a[W-1]}}, a});
    s_val  = a_ext + Q_EXT;
    d_val  = a_ext - Q_EXT;
    s_sh   = s_val >>> PREP_SHIFT;
    d_sh   = d_val >>> PREP_SHIFT;
    s_prod = $signed({{(PW-EW){s_sh[EW-1]}}, s_sh}) * K_EXT;
    d_prod = $signed({{(PW-EW){d_sh[EW-1]}}, d_sh}) * K_EXT;
    x      = s_prod[2*W-2:W-1];
    y      = d_prod[2*W-2:W-1];
  end

  assign unused_bits = ^{s_prod[PW-1:2*W-1], s_prod[W-2:0],
                         d_prod[PW-1:2*W-1], d_prod[W-2:0]};

endmodule

// File: rtl/cordic_hyp_scheduler.sv
// Two-port round-robin sequencer for a single hyperbolic CORDIC core.
// Accepts one job at a time, drives the core until done (or timeout) and
// returns the captured result tagged with the requester ID.
// Optional feature macro: CORDIC_SQRT_PREP_EN (sqrt operand PREP state).
module cordic_hyp_scheduler
  import cordic_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int TIMEOUT = 64
)(
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [1:0]     req_op,
  input  logic [2*W-1:0] req_x,
  input  logic [2*W-1:0] req_y,
  input  logic [2*W-1:0] req_angle,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic           rsp_err,
  output logic [W-1:0]   rsp_x,
  output logic [W-1:0]   rsp_y,
  output logic [W-1:0]   rsp_theta,
  output logic           cordic_en,
  output logic [W-1:0]   cordic_x,
  output logic [W-1:0]   cordic_y,
  output logic [W-1:0]   cordic_angle,
  input  logic           cordic_done,
  input  logic [W-1:0]   cordic_x0,
  input  logic [W-1:0]   cordic_y0,
  input  logic [W-1:0]   cordic_theta
);

  localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t         state, state_nxt;
  logic           ptr;            // requester currently holding priority
  logic [1:0]     gnt;
  logic           gnt_id, gnt_any, prep_go;
  logic [CW-1:0]  cnt;
  logic           cnt_last;
  logic [W-1:0]   op_x, op_y, op_ang;
  logic [W-1:0]   sel_x, sel_y, sel_ang;

  // Round-robin grant: only in IDLE, and only once the core has cleared done
  always_comb begin
    gnt = '0;
    if (state == S_IDLE && !cordic_done && !rst) begin
      if (req_valid[ptr])       gnt[ptr]  = 1'b1;
      else if (req_valid[!ptr]) gnt[!ptr] = 1'b1;
    end
  end

  assign gnt_id    = gnt[1];
  assign gnt_any   = |gnt;
  assign req_ready = gnt;
  assign sel_x     = gnt_id ? req_x[2*W-1:W]     : req_x[W-1:0];
  assign sel_y     = gnt_id ? req_y[2*W-1:W]     : req_y[W-1:0];
  assign sel_ang   = gnt_id ? req_angle[2*W-1:W] : req_angle[W-1:0];
  assign cnt_last  = (cnt == CNT_LAST);

`ifdef CORDIC_SQRT_PREP_EN
  logic [W-1:0] prep_x, prep_y;

  // PREP reads the latched operand a, held in op_x since the grant
  cordic_sqrt_prep #(.W(W)) u_prep (
    .a (op_x),
    .x (prep_x),
    .y (prep_y)
  );

  assign prep_go = req_op[gnt_id];
`else
  logic unused_op;

  // Without the prep logic every job is raw and the op field is ignored
  assign prep_go   = 1'b0;
  assign unused_op = ^req_op;
`endif

  // State register; reset drops cordic_en immediately via the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (gnt_any) state_nxt = prep_go ? S_PREP : S_LAUNCH;
      S_PREP:   state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (cordic_done || cnt_last) state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    cordic_en = (state == S_LAUNCH) || (state == S_WAIT);
    rsp_valid = (state == S_RESP);
  end

  assign cordic_x     = op_x;
  assign cordic_y     = op_y;
  assign cordic_angle = op_ang;

  // Datapath: operand latch, pointer update, timeout counter, result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_x     <= '0;
      rsp_y     <= '0;
      rsp_theta <= '0;
      op_x      <= '0;
      op_y      <= '0;
      op_ang    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            ptr    <= ~gnt_id;   // just-served requester drops to low priority
            rsp_id <= gnt_id;
            op_x   <= sel_x;
            op_y   <= sel_y;
            op_ang <= sel_ang;
          end
        end
`ifdef CORDIC_SQRT_PREP_EN
        S_PREP: begin
          op_x   <= prep_x;
          op_y   <= prep_y;
          op_ang <= '0;
        end
`endif
        S_LAUNCH: cnt <= '0;
        S_WAIT: begin
          if (cordic_done) begin
            rsp_x     <= cordic_x0;
            rsp_y     <= cordic_y0;
            rsp_theta <= cordic_theta;
            rsp_err   <= 1'b0;
          end else if (cnt_last) begin
            rsp_x     <= '0;
            rsp_y     <= '0;
            rsp_theta <= '0;
            rsp_err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_hyp_scheduler.sv
// Self-checking bench for cordic_hyp_scheduler with a behavioural core model.
// Honours CORDIC_SQRT_PREP_EN in its expectations.
module tb_cordic_hyp_scheduler;
  localparam int W = 16;
`ifdef CORDIC_SQRT_PREP_EN
  localparam bit SQRT_ON = 1'b1;
`else
  localparam bit SQRT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_ready, req_op;
  logic [2*W-1:0] req_x, req_y, req_angle;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0]  rsp_x, rsp_y, rsp_theta;
  logic          cordic_en, cordic_done;
  logic [W-1:0]  cordic_x, cordic_y, cordic_angle;
  logic [W-1:0]  core_x0, core_y0, core_theta;

  always #5 clk = ~clk;

  cordic_hyp_scheduler #(.W(W), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_angle(req_angle),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_theta(rsp_theta),
    .cordic_en(cordic_en), .cordic_x(cordic_x), .cordic_y(cordic_y),
    .cordic_angle(cordic_angle), .cordic_done(cordic_done),
    .cordic_x0(core_x0), .cordic_y0(core_y0), .cordic_theta(core_theta)
  );

  // Core model knobs
  int core_lat   = 18;
  bit never_done = 1'b0;
  int done_hold  = 0;
  int ccnt, hold_left;

  // Core model: done rises core_lat cycles after en, lingers done_hold cycles after en drops
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ccnt <= 0; hold_left <= 0; cordic_done <= 1'b0;
      core_x0 <= '0; core_y0 <= '0; core_theta <= '0;
    end else if (cordic_en) begin
      ccnt      <= ccnt + 1;
      hold_left <= done_hold;
      if (!never_done && ccnt == core_lat - 1) begin
        cordic_done <= 1'b1;
        core_x0     <= cordic_x + cordic_y;
        core_y0     <= cordic_x - cordic_y;
        core_theta  <= cordic_angle ^ 16'h1234;
      end
    end else begin
      ccnt <= 0;
      if (hold_left != 0) hold_left <= hold_left - 1;
      else                cordic_done <= 1'b0;
    end
  end

  int total = 0;
  int bad   = 0;
  int model_ptr = 0;
  int last_w = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Operands the core should see for a job
  task automatic exp_ops(input bit sq, input logic [15:0] a, input logic [15:0] y,
                         input logic [15:0] ang, output logic [15:0] ex,
                         output logic [15:0] ey, output logic [15:0] ea);
    int s, d;
    longint ps, pd;
    if (sq) begin
      s  = (int'($signed(a)) + 8192) >>> 2;
      d  = (int'($signed(a)) - 8192) >>> 2;
      ps = longint'(s) * 39485;
      pd = longint'(d) * 39485;
      ex = 16'(ps >>> 15);
      ey = 16'(pd >>> 15);
      ea = 16'h0;
    end else begin
      ex = a; ey = y; ea = ang;
    end
  endtask

  // One complete job: arbitration, launch, wait, response (with optional stall)
  task automatic run_job(input logic [1:0] mask, input logic [1:0] ops,
                         input logic [31:0] xs, input logic [31:0] ys,
                         input logic [31:0] as, input int stall);
    int w, k, bad_hold;
    bit got, sq, to;
    logic [15:0] ex, ey, ea, rx, ry, rt;
    @(negedge clk);
    req_valid = mask; req_op = ops; req_x = xs; req_y = ys; req_angle = as;
    w = (mask == 2'b11) ? model_ptr : (mask[1] ? 1 : 0);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (|req_ready) got = 1'b1;
      else @(negedge clk);
    end
    chk("grant", req_ready, 32'(1) << w);
    last_w    = w;
    model_ptr = 1 - w;
    sq = SQRT_ON && ops[w];
    exp_ops(sq, xs[w*16 +: 16], ys[w*16 +: 16], as[w*16 +: 16], ex, ey, ea);
    @(negedge clk);
    req_valid = 2'b00;
    if (sq) begin
      chk("en_prep_low", cordic_en, 0);
      @(negedge clk);
    end
    chk("en_launch", cordic_en, 1);
    chk("core_x", cordic_x, ex);
    chk("core_y", cordic_y, ey);
    chk("core_ang", cordic_angle, ea);
    to = never_done;
    k = 0; bad_hold = 0;
    while (!rsp_valid && k < 200) begin
      if (!cordic_en || cordic_x !== ex || cordic_y !== ey || cordic_angle !== ea) bad_hold++;
      @(negedge clk);
      k++;
    end
    chk("wait_len", k, to ? 65 : core_lat + 1);
    chk("en_hold", bad_hold, 0);
    chk("resp_en_low", cordic_en, 0);
    rx = to ? 16'h0 : 16'(ex + ey);
    ry = to ? 16'h0 : 16'(ex - ey);
    rt = to ? 16'h0 : (ea ^ 16'h1234);
    chk("rsp_id", rsp_id, w);
    chk("rsp_err", rsp_err, to);
    chk("rsp_x", rsp_x, rx);
    chk("rsp_y", rsp_y, ry);
    chk("rsp_theta", rsp_theta, rt);
    for (int i = 0; i < stall; i++) begin
      req_valid = 2'b11;
      @(negedge clk); #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_x", rsp_x, rx);
      chk("stall_theta", rsp_theta, rt);
      chk("stall_noready", req_ready, 0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("rsp_done", rsp_valid, 0);
  endtask

  initial begin
    int n, viol;
    rst = 1'b1; req_valid = 0; req_op = 0; req_x = 0; req_y = 0; req_angle = 0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_en", cordic_en, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_id", rsp_id, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_rx", rsp_x, 0);
    chk("rst_cx", cordic_x, 0);

    // Directed raw job on requester 0
    run_job(2'b01, 2'b00, {16'h0, 16'h4000}, {16'h0, 16'h1000}, 32'h0, 0);

    // Sqrt job on requester 1, a = 0.9
    run_job(2'b10, 2'b10, {16'd29491, 16'h0}, {16'h0100, 16'h0}, {16'h0200, 16'h0}, 0);

    // Alternation from a fresh reset
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0; model_ptr = 0;
    core_lat = 4;
    for (int i = 0; i < 4; i++) begin
      run_job(2'b11, 2'b00, {16'h2222, 16'h1111}, {16'h0044, 16'h0033}, {16'h0066, 16'h0055}, 0);
      chk("alt_seq", last_w, i % 2);
    end

    // Timeout: core never finishes
    never_done = 1'b1;
    run_job(2'b01, 2'b00, {16'h0, 16'h1234}, {16'h0, 16'h0567}, {16'h0, 16'h0089}, 0);
    never_done = 1'b0;

    // Response stalled for 10 cycles
    core_lat = 7;
    run_job(2'b10, 2'b00, {16'h3000, 16'h0}, {16'h0F00, 16'h0}, {16'h0AA0, 16'h0}, 10);

    // Grant withheld while the core still reports done
    done_hold = 8;
    run_job(2'b01, 2'b00, {16'h0, 16'h0100}, {16'h0, 16'h0010}, {16'h0, 16'h0001}, 0);
    req_valid = 2'b01;
    n = 0; viol = 0;
    while (cordic_done && n < 20) begin
      if (req_ready !== 2'b00) viol++;
      @(negedge clk); #1;
      n++;
    end
    chk("withhold_rdy", viol, 0);
    chk("withhold_len", n, 8);
    chk("grant_after_done", req_ready, 2'b01);
    req_valid = 2'b00;
    done_hold = 0;

    // Reset during WAIT aborts the job and restores priority to requester 0
    core_lat = 40;
    @(negedge clk);
    req_valid = 2'b01; req_x = 32'h0000_0500;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (5) @(negedge clk);
    chk("pre_rst_en", cordic_en, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_en", cordic_en, 0);
    chk("rst_mid_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0; model_ptr = 0;
    core_lat = 18;
    run_job(2'b11, 2'b00, {16'h7000, 16'h0400}, {16'h0001, 16'h0200}, {16'h0002, 16'h0100}, 0);
    chk("post_rst_req0", last_w, 0);

    // Randomized jobs
    for (int i = 0; i < 16; i++) begin
      core_lat = $urandom_range(1, 40);
      run_job(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom,
              $urandom, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_hyp_scheduler.md
# cordic_hyp_scheduler

Sequencer and two-port arbiter for a single `cordic_hyperbolic_mode` instance. It accepts jobs from two requesters over valid/ready and picks between them round-robin. For each job it drives the CORDIC `en`/`angle`/`X`/`Y`, waits for `done`, then returns `X0`/`Y0`/`theta` tagged with the requester ID. It sits between the compute clients and the CORDIC core and is the only block that drives the core.

## Interface
- `W`, 16, operand/result width (signed, Q1.15)
- `TIMEOUT`, 64, maximum cycles to wait for `cordic_done` before aborting
- `clk  in  1  clock, rising edge`
- `rst  in  1  reset, asynchronous, active-high`
- `req_valid  in  2  per-requester job valid (bit n = requester n)`
- `req_ready  out  2  per-requester accept; at most one bit high`
- `req_op  in  2  per-requester op: 0 raw, 1 sqrt (see Configuration)`
- `req_x  in  2*W  packed X operands (raw) or operand a (sqrt); [W-1:0] = req 0`
- `req_y  in  2*W  packed Y operands (raw only)`
- `req_angle  in  2*W  packed angle operands (raw only)`
- `rsp_valid  out  1  result valid`
- `rsp_ready  in  1  result accept`
- `rsp_id  out  1  requester that owns the result`
- `rsp_err  out  1  job aborted by timeout; data fields are zero`
- `rsp_x, rsp_y, rsp_theta  out  W each  captured X0, Y0, theta`
- `cordic_en, cordic_x, cordic_y, cordic_angle  out  1/W/W/W  to core`
- `cordic_done  in  1  from core; high = result valid`
- `cordic_x0, cordic_y0, cordic_theta  in  W each  from core`

## Operation
- FSM states: IDLE, PREP, LAUNCH, WAIT, RESP.
- **IDLE.** Grants when any `req_valid` is high and `cordic_done` is low.
  - Round-robin priority: last-served requester gets low priority. After reset requester 0 has priority.
  - `req_ready[n]` is high for exactly that cycle. Operands and op are latched and `rsp_id` is set.
  - Go to PREP if op=1, else LAUNCH.
- **PREP (1 cycle).** Builds the sqrt operands from a=`req_x`:
  - s=a+0x2000 and d=a−0x2000 (18-bit signed), each arithmetic-shifted right by 2.
  - Each is multiplied by KH=39485 (1.205·2^15). Keep product bits [30:15], truncated.
  - X←s term, Y←d term, angle←0. Then LAUNCH.
- **LAUNCH.** Assert `cordic_en` with the latched operands; load the timeout counter with 0. Go to WAIT.
- **WAIT.**
  - `cordic_en` stays high and operands are held stable. The counter increments each cycle.
  - When `cordic_done` is sampled high: capture x0/y0/theta, set `rsp_err`=0, go to RESP.
  - When the counter reaches TIMEOUT−1 first: zero the result fields, set `rsp_err`=1, go to RESP.
- **RESP.** `cordic_en`=0 and `rsp_valid`=1, with data stable until `rsp_ready`. Return to IDLE on the `rsp_valid`&&`rsp_ready` cycle.
- Jobs are not pipelined; one outstanding at most. A requester's valid is ignored while any job is in flight.

## Timing
- Reset values: `cordic_en`, `rsp_valid`, `rsp_err`, `rsp_id`, and `req_ready` all 0. All data outputs 0. Priority pointer at requester 0. State IDLE.
- Reset mid-job aborts the job: `cordic_en` drops asynchronously and no response is issued.
- Latency from grant to `cordic_en`:
  - raw: 1 cycle;
  - sqrt: 2 cycles.
- `rsp_valid` rises the cycle after `cordic_done` is sampled high. The earliest next grant is the cycle after the response handshake.
- Both requesters valid in the same cycle → the pointer decides. Pointer updates on grant.
- `cordic_done` still high in IDLE (core not yet cleared) → grant is withheld until it is low.
- `rsp_ready` held low → FSM stalls in RESP indefinitely; no new grants.

## Configuration
- `CORDIC_SQRT_PREP_EN` defined: PREP state and KH multiplier are compiled in; op=1 behaves as above.
- `CORDIC_SQRT_PREP_EN` undefined: PREP and multiplier are removed; `req_op` is ignored and every job is raw.

## Structure
- Package `cordic_pkg`:
  - FSM state enum;
  - constants KH=39485, QUARTER=0x2000, PREP_SHIFT=2;
  - default W.
- One sub-module, `cordic_sqrt_prep`: combinational s/d/scale from a; instantiated only under the macro.
- Arbiter pointer, FSM and timeout counter live in the top.

## Test plan
- Raw job on req 0 (x=0x4000, y=0x1000, angle=0); core model raises done 18 cycles after en → `cordic_en` 1 cycle after grant. Response: id=0, err=0, data equals model output.
- Sqrt job on req 1 with a=29491 (0.9) → core sees X=11350, Y=6415, angle=0. Response id=1.
- Both requesters valid continuously → grants alternate 0,1,0,1 starting with 0 after reset.
- Core model never asserts done, TIMEOUT=64 → response after 64 WAIT cycles with err=1 and zero data. `cordic_en` low in RESP.
- `rsp_ready` low for 10 cycles → `rsp_valid` and data held constant, no new `req_ready`.
- `rst` pulsed during WAIT → `cordic_en`=0 immediately. After release, a new req 0 job completes normally with priority at requester 0.
